uart_tx_serializer: RTL

- UART transmitter: accepts a parallel word on a start handshake and shifts it out serially as an asynchronous frame: start bit, data LSB-first, optional parity, stop bit(s).
- Sits between the UART top level and the serial line. It is driven by the FIFO in normal mode and by the BIST controller in BIST mode.
- Its Tx_Busy is the busy indication the BIST controller and the top level use to sequence transmissions.

---
 rtl/uart_tx_serializer_if.sv | 32 +++
 rtl/uart_tx_serializer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_serializer_if.sv
// uart_tx_serializer_if
//   Handshake and serial-line bundle for the UART transmit serializer.
//   master : requester side (FIFO or BIST controller) driving the start
//            request, data word and clear-to-send, observing line and status.
//   slave  : serializer side.
// Signals:
//   Tx_Start   - level request to send Tx_Data_In
//   Tx_Data_In - parallel word to transmit (DATA_BITS wide)
//   CTS        - clear-to-send from the far-end receiver
//   Tx_Out     - serial line, idle-high
//   Tx_Busy    - high while a frame is on the line
//   Tx_Done    - one-cycle pulse after each completed frame
interface uart_tx_serializer_if #(
  parameter int DATA_BITS = 8
);
  logic                 Tx_Start;
  logic [DATA_BITS-1:0] Tx_Data_In;
  logic                 CTS;
  logic                 Tx_Out;
  logic                 Tx_Busy;
  logic                 Tx_Done;

  modport master (
    output Tx_Start, Tx_Data_In, CTS,
    input  Tx_Out, Tx_Busy, Tx_Done
  );

  modport slave (
    input  Tx_Start, Tx_Data_In, CTS,
    output Tx_Out, Tx_Busy, Tx_Done
  );
endinterface

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer
//   UART transmitter: on a start handshake (Tx_Start=1 with CTS=1 in IDLE)
//   latches a parallel word and shifts it out as an asynchronous frame:
//   start bit, DATA_BITS data bits LSB-first, optional even parity bit,
//   STOP_BITS stop bits. Each bit lasts CLKS_PER_BIT clock cycles.
// Build option:
//   UART_TX_PARITY_EN - when defined, a PARITY bit (even parity of the
//   latched word) is inserted between the data and stop bits.
// Ports:
//   Clk - system clock, rising edge
//   Rst - asynchronous, active-high reset; aborts any frame in progress
//   bus - uart_tx_serializer_if.slave:
//         Tx_Start, Tx_Data_In, CTS in; Tx_Out, Tx_Busy, Tx_Done out
// Parameters:
//   DATA_BITS    - data word width / data bits per frame
//   CLKS_PER_BIT - clock cycles per serial bit (>= 2)
//   STOP_BITS    - stop bits per frame (1 or 2)
module uart_tx_serializer #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic                   Clk,
  input  logic                   Rst,
  uart_tx_serializer_if.slave    bus
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(DATA_BITS + 1);

  localparam logic [BAUD_W-1:0] BAUD_LAST     = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  DATA_BIT_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  STOP_BIT_LAST = BIT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t                state_q, state_d;
  logic [BAUD_W-1:0]     baud_q, baud_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [DATA_BITS-1:0]  shift_q, shift_d;
  logic                  tx_out_q, tx_out_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  baud_wrap;
`ifdef UART_TX_PARITY_EN
  logic                  parity_q, parity_d;
`endif

  assign baud_wrap = (baud_q == BAUD_LAST);

  // Next-state and next-output logic. Outputs are decoded from the next
  // state so that Tx_Out/Tx_Busy/Tx_Done come straight from flops and the
  // start bit appears on the line the cycle right after the launch edge.
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    done_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.Tx_Start && bus.CTS) begin
          shift_d  = bus.Tx_Data_In;
          baud_d   = '0;
          bit_d    = '0;
`ifdef UART_TX_PARITY_EN
          // Parity is captured at launch because the shift register
          // no longer holds the whole word by the time it is sent.
          parity_d = ^bus.Tx_Data_In;
`endif
          state_d  = S_START;
        end
      end

      S_START: begin
        if (baud_wrap) begin
          baud_d  = '0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      S_DATA: begin
        if (baud_wrap) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == DATA_BIT_LAST) begin
            bit_d   = '0;
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (baud_wrap) begin
          baud_d  = '0;
          state_d = S_STOP;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
`endif

      S_STOP: begin
        // The bit counter is reused to count stop bits.
        if (baud_wrap) begin
          baud_d = '0;
          if (bit_q == STOP_BIT_LAST) begin
            bit_d   = '0;
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        baud_d  = '0;
        bit_d   = '0;
      end
    endcase
  end

  always_comb begin
    tx_out_d = 1'b1;
    busy_d   = (state_d != S_IDLE);
    case (state_d)
      S_IDLE:   tx_out_d = 1'b1;
      S_START:  tx_out_d = 1'b0;
      S_DATA:   tx_out_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_out_d = parity_d;
`endif
      S_STOP:   tx_out_d = 1'b1;
      default:  tx_out_d = 1'b1;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_out_q <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_out_q <= tx_out_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign bus.Tx_Out  = tx_out_q;
  assign bus.Tx_Busy = busy_q;
  assign bus.Tx_Done = done_q;

endmodule
